// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Input conditioner for the board's slide switches and push-buttons. Each
// raw pin is brought into the i_clk domain through a plain flop chain. It is
// then debounced: a new level is accepted only after it has been seen on
// DEBOUNCE_CYCLES consecutive edges. The clean levels are registered and
// drive the `in` bus of the LED logic. One-cycle rise/fall pulses are
// produced per bit, together with an aggregate change flag.
//
// Ports
//   i_clk         in   1      system clock, all state updates on rising edge
//   i_rst         in   1      synchronous active-high reset
//   i_sw          in   WIDTH  raw asynchronous switch/button levels
//   o_sw          out  WIDTH  debounced stable level per bit
//   o_rise        out  WIDTH  one-cycle pulse when o_sw bit goes 0->1
//   o_fall        out  WIDTH  one-cycle pulse when o_sw bit goes 1->0
//   o_any_change  out  1      OR of all rise/fall pulses, aligned with them
//
// Every output is driven straight from a flop. There is no combinational
// path from i_sw to any output.
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH           = 14,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any_change
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. The acceptance edge
  // clears it instead of incrementing it, so clog2 bits are always enough.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

  logic [WIDTH-1:0] accept_s;
  logic [WIDTH-1:0] sw_nxt_s;
  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] fall_nxt_s;
  logic             any_nxt_s;

  logic [WIDTH-1:0] sw_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic             any_r;

  // The debounce logic only ever sees the last synchroniser stage.
  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser: a plain shift chain per bit, with nothing between stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= i_sw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Per-bit qualification: count consecutive disagreeing samples.
  // A single agreeing sample restarts the count from zero.
  always_comb begin
    accept_s = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      cnt_nxt_s[b] = CNT_ZERO;
      if (sync_s[b] == sw_r[b]) begin
        cnt_nxt_s[b] = CNT_ZERO;
      end else if (cnt_r[b] == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        accept_s[b]  = 1'b1;
        cnt_nxt_s[b] = CNT_ZERO;
      end else begin
        cnt_nxt_s[b] = cnt_r[b] + CNT_ONE;
      end
    end
  end

  // Next stable level and edge pulses derived from the acceptance mask.
  always_comb begin
    sw_nxt_s   = (sw_r & ~accept_s) | (sync_s & accept_s);
    rise_nxt_s = accept_s & sync_s;
    fall_nxt_s = accept_s & ~sync_s;
    any_nxt_s  = |(rise_nxt_s | fall_nxt_s);
  end

  // Qualification counters. Reset discards any partial count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < WIDTH; b++) begin
        cnt_r[b] <= CNT_ZERO;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        cnt_r[b] <= cnt_nxt_s[b];
      end
    end
  end

  // Output registers: stable levels, pulses and the aggregate change flag.
  // All of them update on the same edge, so they stay aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_r   <= {WIDTH{1'b0}};
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
      any_r  <= 1'b0;
    end else begin
      sw_r   <= sw_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
      any_r  <= any_nxt_s;
    end
  end

  assign o_sw         = sw_r;
  assign o_rise       = rise_r;
  assign o_fall       = fall_r;
  assign o_any_change = any_r;

endmodule

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// Self-checking bench for switch_debounce (WIDTH=14, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). It has three parts:
//   - a vector table for reset and multi-bit transitions;
//   - hand sequences for the clean step, glitch, bounce and mid-count reset;
//   - a random phase checked against a window-based reference model.
// The model accepts a new level for a bit when the last DEBOUNCE_CYCLES
// samples seen after the synchroniser delay all differ from that bit's
// current stable level.
// ---------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int W  = 14;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         i_clk;
  logic         i_rst;
  logic [W-1:0] i_sw;
  logic [W-1:0] o_sw;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;
  logic         o_any_change;

  int checks   = 0;
  int failures = 0;

  switch_debounce #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_sw(i_sw),
    .o_sw(o_sw),
    .o_rise(o_rise),
    .o_fall(o_fall),
    .o_any_change(o_any_change)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_pipe [$];
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_sw, m_rise, m_fall;
  logic         m_any;

  task automatic model_edge(input logic rst, input logic [W-1:0] sw);
    logic [W-1:0] seen;
    logic [W-1:0] acc;
    logic         all_diff;
    if (rst) begin
      m_pipe.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back({W{1'b0}});
      m_hist.delete();
      m_sw   = '0;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
    end else begin
      // The value the debouncer sees now was captured SS edges ago.
      seen = m_pipe.pop_back();
      m_pipe.push_front(sw);
      m_hist.push_back(seen);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      acc = '0;
      if (m_hist.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int i = 0; i < DC; i++) begin
            if (m_hist[i][b] == m_sw[b]) all_diff = 1'b0;
          end
          acc[b] = all_diff;
        end
      end
      m_rise = acc & ~m_sw;
      m_fall = acc & m_sw;
      m_any  = |(m_rise | m_fall);
      m_sw   = m_sw ^ acc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one clock edge, then compare the DUT against the model.
  task automatic step(input logic rst, input logic [W-1:0] sw);
    i_rst = rst;
    i_sw  = sw;
    @(posedge i_clk);
    #1;
    model_edge(rst, sw);
    check("model_sw",   o_sw,         m_sw);
    check("model_rise", o_rise,       m_rise);
    check("model_fall", o_fall,       m_fall);
    check("model_any",  o_any_change, m_any);
    check("rise_fall_excl", o_rise & o_fall, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [W-1:0] sw;
    logic [W-1:0] esw;
    logic [W-1:0] erise;
    logic [W-1:0] efall;
    logic         eany;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic rst, input logic [W-1:0] sw, input logic [W-1:0] esw,
                     input logic [W-1:0] er, input logic [W-1:0] ef, input logic ea);
    vec_t v;
    v.rst = rst; v.sw = sw; v.esw = esw; v.erise = er; v.efall = ef; v.eany = ea;
    tbl.push_back(v);
  endtask

  logic [W-1:0] cur;
  logic [31:0]  mask;
  int           n_pulse;
  int           at;

  initial begin
    i_rst = 1'b1;
    i_sw  = '0;

    // Reset with all inputs high, then release at edge r.
    add(1'b1, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    add(1'b1, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    add(1'b0, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000, 1'b1);
    add(1'b0, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000, 1'b0);
    // Ten bits fall together.
    for (int i = 0; i < 5; i++) add(1'b0, 14'h000F, 14'h3FFF, 14'h0000, 14'h0000, 1'b0);
    add(1'b0, 14'h000F, 14'h000F, 14'h0000, 14'h3FF0, 1'b1);
    add(1'b0, 14'h000F, 14'h000F, 14'h0000, 14'h0000, 1'b0);
    // Simultaneous mixed edges: 000F -> 00F0.
    for (int i = 0; i < 5; i++) add(1'b0, 14'h00F0, 14'h000F, 14'h0000, 14'h0000, 1'b0);
    add(1'b0, 14'h00F0, 14'h00F0, 14'h00F0, 14'h000F, 1'b1);
    add(1'b0, 14'h00F0, 14'h00F0, 14'h0000, 14'h0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].sw);
      check("tbl_sw",   o_sw,         tbl[i].esw);
      check("tbl_rise", o_rise,       tbl[i].erise);
      check("tbl_fall", o_fall,       tbl[i].efall);
      check("tbl_any",  o_any_change, tbl[i].eany);
    end

    // Return to a clean all-zero state.
    cur = '0;
    step(1'b1, cur);
    step(1'b1, cur);
    repeat (8) step(1'b0, cur);

    // Clean step on bit 0: captured at edge k, accepted at edge k+5.
    cur[0] = 1'b1;
    step(1'b0, cur);
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, cur);
      check("step_hold", o_sw, 32'h0);
    end
    step(1'b0, cur);
    check("step_sw",   o_sw,   32'h1);
    check("step_rise", o_rise, 32'h1);
    step(1'b0, cur);
    check("step_rise_end", o_rise, 32'h0);
    check("step_sw_keep",  o_sw,   32'h1);

    // Glitch on bit 3: high for 3 cycles only.
    cur[3] = 1'b1;
    repeat (3) step(1'b0, cur);
    cur[3] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step(1'b0, cur);
      check("glitch_sw3",   o_sw[3],         32'h0);
      check("glitch_pulse", o_rise | o_fall, 32'h0);
    end

    // Bounce on bit 5: 1,0,1,0,1, then hold 1.
    for (int j = 0; j < 5; j++) begin
      cur[5] = (j % 2 == 0);
      step(1'b0, cur);
    end
    n_pulse = 0;
    at      = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, cur);
      if (o_rise[5]) begin
        n_pulse++;
        at = j;
      end
    end
    check("bounce_pulses", n_pulse, 32'd1);
    check("bounce_delay",  at,      32'd5);

    // Reset in the middle of qualifying bit 7 (counter at 2).
    cur[7] = 1'b1;
    step(1'b0, cur);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, cur);
      check("mid_sw7", o_sw[7], 32'h0);
    end
    step(1'b1, cur);
    check("mid_rst_sw",   o_sw,         32'h0);
    check("mid_rst_rise", o_rise,       32'h0);
    check("mid_rst_any",  o_any_change, 32'h0);
    n_pulse = 0;
    at      = -1;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, cur);
      if (j < 5) check("mid_sw7_wait", o_sw[7], 32'h0);
      if (o_rise[7]) begin
        n_pulse++;
        at = j;
      end
    end
    check("mid_pulses", n_pulse, 32'd1);
    check("mid_delay",  at,      32'd5);

    // Randomised phase: sparse per-bit flips plus occasional resets.
    for (int n = 0; n < 3000; n++) begin
      mask = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) mask = 32'h0;
      cur = cur ^ mask[W-1:0];
      step(($urandom_range(0, 299) == 0), cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
